// File: rtl/phy_rx_lanes_if.sv
// Lane-side bundle of the 4-lane PHY receiver: serial input plus the four
// parallel lane outputs and the link-active flag.
interface phy_rx_lanes_if;
    logic       data_in;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       valid_out0;
    logic       valid_out1;
    logic       valid_out2;
    logic       valid_out3;
    logic       active;

    // Master drives the serial stream and consumes the lanes.
    modport master (
        output data_in,
        input  out0, out1, out2, out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3,
        input  active
    );

    // Slave is the receiver itself.
    modport slave (
        input  data_in,
        output out0, out1, out2, out3,
        output valid_out0, valid_out1, valid_out2, valid_out3,
        output active
    );
endinterface

// File: rtl/phy_rx_lanes.sv
// 4-lane PHY receiver: COM byte alignment, MSB-first deserialization and
// round-robin lane distribution. Define PHY_RX_LOS_EN for the loss-of-signal watchdog.
module phy_rx_lanes #(
    parameter logic [7:0]  COM         = 8'hBC,
    parameter logic [7:0]  IDLE        = 8'h7C,
    parameter int unsigned ACTIVE_COMS = 4
`ifdef PHY_RX_LOS_EN
    ,
    parameter int unsigned LOS_BYTES   = 64
`endif
) (
    input  logic          clk_32f,
    input  logic          reset_L,
    phy_rx_lanes_if.slave rx
);

    localparam int unsigned LANES     = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned PTR_W     = 2;
    localparam int unsigned COM_CNT_W = $clog2(ACTIVE_COMS + 1);
`ifdef PHY_RX_LOS_EN
    localparam int unsigned LOS_W     = $clog2(LOS_BYTES + 1);
`endif

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    // Only the last seven bits are kept; the incoming bit completes the byte.
    logic [BYTE_W-2:0]               sr_q, sr_d;
    logic [BIT_CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [COM_CNT_W-1:0]            com_cnt_q, com_cnt_d;
    logic [PTR_W-1:0]                lane_ptr_q, lane_ptr_d;
    logic [LANES-1:0][BYTE_W-1:0]    out_q, out_d;
    logic [LANES-1:0]                valid_q, valid_d;
    logic                            active_q, active_d;
`ifdef PHY_RX_LOS_EN
    logic [LOS_W-1:0]                los_cnt_q, los_cnt_d;
`endif

    logic [BYTE_W-1:0]               byte_c;
    logic                            byte_end_c;

    assign byte_c     = {sr_q, rx.data_in};
    assign byte_end_c = (bit_cnt_q == BIT_CNT_W'(7));

    // Next-state, alignment and lane distribution.
    always_comb begin
        state_d    = state_q;
        sr_d       = byte_c[BYTE_W-2:0];
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
        com_cnt_d  = com_cnt_q;
        lane_ptr_d = lane_ptr_q;
        out_d      = out_q;
        valid_d    = valid_q;
`ifdef PHY_RX_LOS_EN
        los_cnt_d  = los_cnt_q;
`endif

        case (state_q)
            SEARCH: begin
                bit_cnt_d = '0;
                if (byte_c == COM) begin
                    com_cnt_d = COM_CNT_W'(1);
                    state_d   = COUNT;
                end
            end

            COUNT: begin
                if (byte_end_c) begin
                    if (byte_c == COM) begin
                        com_cnt_d = com_cnt_q + COM_CNT_W'(1);
                        if (com_cnt_d == COM_CNT_W'(ACTIVE_COMS)) begin
                            state_d    = ACTIVE;
                            lane_ptr_d = '0;
`ifdef PHY_RX_LOS_EN
                            los_cnt_d  = '0;
`endif
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                if (byte_end_c) begin
                    if (byte_c == COM) begin
                        // COM reframes the lanes without touching them.
                        lane_ptr_d = '0;
`ifdef PHY_RX_LOS_EN
                        los_cnt_d  = '0;
`endif
                    end else begin
`ifdef PHY_RX_LOS_EN
                        los_cnt_d = los_cnt_q + LOS_W'(1);
                        if (los_cnt_d == LOS_W'(LOS_BYTES)) begin
                            state_d   = SEARCH;
                            valid_d   = '0;
                            com_cnt_d = '0;
                        end else
`endif
                        begin
                            if (byte_c == IDLE) begin
                                valid_d[lane_ptr_q] = 1'b0;
                            end else begin
                                out_d[lane_ptr_q]   = byte_c;
                                valid_d[lane_ptr_q] = 1'b1;
                            end
                            lane_ptr_d = lane_ptr_q + PTR_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d   = SEARCH;
                com_cnt_d = '0;
                valid_d   = '0;
            end
        endcase

        active_d = (state_d == ACTIVE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= SEARCH;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            lane_ptr_q <= '0;
            out_q      <= '0;
            valid_q    <= '0;
            active_q   <= 1'b0;
`ifdef PHY_RX_LOS_EN
            los_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            lane_ptr_q <= lane_ptr_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
`ifdef PHY_RX_LOS_EN
            los_cnt_q  <= los_cnt_d;
`endif
        end
    end

    assign rx.out0       = out_q[0];
    assign rx.out1       = out_q[1];
    assign rx.out2       = out_q[2];
    assign rx.out3       = out_q[3];
    assign rx.valid_out0 = valid_q[0];
    assign rx.valid_out1 = valid_q[1];
    assign rx.valid_out2 = valid_q[2];
    assign rx.valid_out3 = valid_q[3];
    assign rx.active     = active_q;

endmodule
